sample_stream_tx: RTL and testbench

// Frame-based transmitter that drives the valid/ready sample stream into the

---
 rtl/sample_stream_tx_if.sv | 29 ++
 rtl/sample_stream_tx.sv | 198 +++++++++++++++++++
 tb/tb_sample_stream_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_stream_tx_if.sv
// sample_stream_tx_if
//   Valid/ready beat stream from the frame transmitter to the receive-side
//   input FIFO.
//   out_valid  beat valid (master -> slave)
//   data_out   beat data  (master -> slave)
//   out_last   final beat of a frame (master -> slave)
//   ready_out  slave can accept a beat (slave -> master)
interface sample_stream_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_last;
  logic                  ready_out;

  modport master (
    output out_valid,
    output data_out,
    output out_last,
    input  ready_out
  );

  modport slave (
    input  out_valid,
    input  data_out,
    input  out_last,
    output ready_out
  );
endinterface

// File: rtl/sample_stream_tx.sv
// sample_stream_tx
//   Captures free-running ADC samples into a small skid FIFO and emits exactly
//   FRAME_LEN beats per frame on a valid/ready stream, tagging the final beat.
//   The output register acts as the head stage in front of the skid FIFO, so a
//   sample arriving while the stream is idle is on data_out one cycle later.
//
// Ports
//   clk         single clock, all logic on posedge
//   reset       asynchronous, active-high
//   start       pulse: begin one frame (only honoured in IDLE)
//   abort       pulse: drop the current frame and return to IDLE
//   adc_valid   ADC sample strobe (cannot be stalled)
//   adc_data    ADC sample
//   bus         beat stream (out_valid/data_out/out_last, ready_out)
//   busy        state != IDLE
//   frame_done  1-cycle pulse after the last beat handshakes
//   sample_idx  beats handshaken in the current frame
//   drop_count  dropped ADC samples, saturating at 255
//   overflow    sticky: any drop since reset
//
// State table
//   S_IDLE   | waiting for start; ADC ignored, counters hold last frame values
//   S_STREAM | capturing ADC samples until FRAME_LEN have been accepted
//   S_FLUSH  | capture complete; draining FIFO until the last beat handshakes
module sample_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  sample_stream_tx_if.master    bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  sample_idx,
  output logic [7:0]            drop_count,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam logic [PTR_W:0]       FULL_CNT = (PTR_W + 1)'(SKID_DEPTH);
  localparam logic [CNT_WIDTH-1:0] FRAME_V  = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_V   = CNT_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t                state;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  out_last_q;

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fifo_cnt;

  // captured: samples accepted this frame; loaded: beats moved into the
  // output register this frame (drives out_last tagging).
  logic [CNT_WIDTH-1:0]  captured;
  logic [CNT_WIDTH-1:0]  loaded;

  logic                  push_req;
  logic                  fire;
  logic                  head_free;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  bypass;
  logic                  fifo_wr;
  logic                  drop;
  logic                  accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state != S_IDLE);

  always_comb begin
    push_req   = (state == S_STREAM) && adc_valid && !abort;
    fire       = out_valid_q && bus.ready_out;
    head_free  = !out_valid_q || fire;
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == FULL_CNT);
    pop        = head_free && !fifo_empty;
    // Empty FIFO and free head: the sample goes straight to the output
    // register so latency stays at one cycle.
    bypass     = head_free && fifo_empty && push_req;
    // A pop frees an entry in the same cycle, so push into a full FIFO is
    // legal whenever the head is also draining.
    fifo_wr    = push_req && !bypass && (!fifo_full || pop);
    drop       = push_req && !bypass && fifo_full && !pop;
    accept     = bypass || fifo_wr;
    load       = pop || bypass;
    load_data  = pop ? mem[rd_ptr] : adc_data;
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_last_q  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      captured    <= '0;
      loaded      <= '0;
      sample_idx  <= '0;
      frame_done  <= 1'b0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_STREAM;
              captured   <= '0;
              loaded     <= '0;
              sample_idx <= '0;
            end
          end
          default: begin
            if (load) begin
              out_valid_q <= 1'b1;
              data_out_q  <= load_data;
              out_last_q  <= (loaded == LAST_V);
              loaded      <= loaded + 1'b1;
            end else if (fire) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end

            if (pop) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_wr) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            case ({fifo_wr, pop})
              2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
              2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
              default: fifo_cnt <= fifo_cnt;
            endcase

            if (accept) begin
              captured <= captured + 1'b1;
              if (captured + 1'b1 == FRAME_V) begin
                state <= S_FLUSH;
              end
            end

            if (drop) begin
              overflow <= 1'b1;
              if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
            end

            if (fire) begin
              sample_idx <= sample_idx + 1'b1;
              if (out_last_q) begin
                state      <= S_IDLE;
                frame_done <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_stream_tx.sv
// tb_sample_stream_tx
//   Directed bench for sample_stream_tx: normal frame, stall with drops,
//   random handshake, abort, ignored start, async reset and drop saturation.
module tb_sample_stream_tx;
  localparam int DW = 16;
  localparam int FL = 64;
  localparam int SD = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] sample_idx;
  logic [7:0]    drop_count;
  logic          overflow;

  sample_stream_tx_if #(.DATA_WIDTH(DW)) bus_if ();

  sample_stream_tx #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .SKID_DEPTH(SD),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .bus       (bus_if),
    .busy      (busy),
    .frame_done(frame_done),
    .sample_idx(sample_idx),
    .drop_count(drop_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            beats[$];
  int            last_pos[$];
  int            done_cnt;
  logic [DW-1:0] next_val;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge to the next, record handshaken beats and
  // check that a stalled beat holds.
  task automatic step(input bit st, input bit ab, input bit av, input bit rdy);
    logic          pv;
    logic          pl;
    logic [DW-1:0] pd;
    start            = st;
    abort            = ab;
    adc_valid        = av;
    adc_data         = next_val;
    bus_if.ready_out = rdy;
    pv = bus_if.out_valid;
    pd = bus_if.data_out;
    pl = bus_if.out_last;
    @(posedge clk);
    if (av) next_val++;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (pv && rdy && !ab) begin
      beats.push_back(int'(pd));
      if (pl) begin
        last_pos.push_back(beats.size() - 1);
        chk_eq("done_after_last", frame_done, 1);
        chk_eq("idle_after_last", busy, 0);
      end
    end else if (pv && !ab) begin
      chk_eq("stall_valid", bus_if.out_valid, 1);
      chk_eq("stall_data", bus_if.data_out, pd);
      chk_eq("stall_last", bus_if.out_last, pl);
    end
    if (frame_done) done_cnt++;
  endtask

  // Start a frame and run until frame_done or the cycle budget runs out.
  // Ready is low for cycles stall_lo..stall_hi; rand_io randomises both sides.
  task automatic run_frame(input int stall_lo, input int stall_hi, input bit rand_io,
                           input int restart_at, input int max_cyc);
    bit got_done;
    bit av;
    bit rdy;
    beats.delete();
    last_pos.delete();
    done_cnt = 0;
    got_done = 0;
    step(1, 0, 0, 1);
    for (int c = 1; c < max_cyc && !got_done; c++) begin
      av  = rand_io ? bit'($urandom_range(0, 1)) : 1'b1;
      rdy = rand_io ? ($urandom_range(0, 3) != 0) : !(c >= stall_lo && c <= stall_hi);
      step(c == restart_at, 0, av, rdy);
      if (done_cnt > 0) got_done = 1;
    end
    chk_eq("frame_timeout", got_done, 1);
    chk_eq("beat_count", beats.size(), FL);
    chk_eq("last_count", last_pos.size(), 1);
    if (last_pos.size() > 0) chk_eq("last_position", last_pos[0], FL - 1);
    chk_eq("sample_idx_end", sample_idx, FL);
  endtask

  function automatic int bad_increasing();
    int bad = 0;
    for (int i = 1; i < beats.size(); i++)
      if (beats[i] <= beats[i-1]) bad++;
    return bad;
  endfunction

  function automatic int bad_contig(input int base);
    int bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] != base + i) bad++;
    return bad;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int d0;
    int nb;
    reset            = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    adc_valid        = 1'b0;
    adc_data         = '0;
    bus_if.ready_out = 1'b0;
    next_val         = '0;
    done_cnt         = 0;

    @(negedge clk);
    chk_eq("rst_out_valid", bus_if.out_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_drop_count", drop_count, 0);
    chk_eq("rst_overflow", overflow, 0);
    chk_eq("rst_sample_idx", sample_idx, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: continuous ADC, always ready -> beats 0..63
    next_val = '0;
    run_frame(1000, 0, 0, -1, 400);
    chk_eq("t1_data_order", bad_contig(0), 0);
    chk_eq("t1_drop_count", drop_count, 0);
    chk_eq("t1_overflow", overflow, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_eq("t1_single_done", done_cnt, 1);

    // 2: ready low for 10 cycles mid-frame -> 6 drops (14..19)
    next_val = '0;
    run_frame(11, 20, 0, -1, 400);
    chk_eq("t2_drop_count", drop_count, 6);
    chk_eq("t2_overflow", overflow, 1);
    if (beats.size() == FL) begin
      chk_eq("t2_beat13", beats[13], 13);
      chk_eq("t2_beat14", beats[14], 20);
      chk_eq("t2_beat63", beats[63], 69);
    end
    chk_eq("t2_increasing", bad_increasing(), 0);

    // 3: random ready and ADC strobes
    v0 = int'(next_val);
    d0 = int'(drop_count);
    run_frame(1000, 0, 1, -1, 2000);
    chk_eq("t3_increasing", bad_increasing(), 0);
    if (beats.size() == FL) begin
      chk_eq("t3_first", beats[0], v0);
      chk_eq("t3_span", beats[63] - beats[0] + 1, FL + int'(drop_count) - d0);
    end

    // 4: abort after 20 beats with 3 samples queued
    d0 = int'(drop_count);
    beats.delete();
    last_pos.delete();
    done_cnt = 0;
    step(1, 0, 0, 1);
    for (int c = 1; c < 400 && beats.size() < 20; c++)
      step(0, 0, 1, !(c >= 5 && c <= 7));
    chk_eq("t4_reach20", beats.size(), 20);
    step(0, 1, 1, 0);
    chk_eq("t4_valid_after_abort", bus_if.out_valid, 0);
    chk_eq("t4_busy_after_abort", busy, 0);
    nb = beats.size();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1);
      chk_eq("t4_idle_valid", bus_if.out_valid, 0);
    end
    chk_eq("t4_no_done", done_cnt, 0);
    chk_eq("t4_no_beats", beats.size(), nb);
    chk_eq("t4_drop_kept", drop_count, d0);
    chk_eq("t4_overflow_kept", overflow, 1);

    // 4/5: fresh frame, with a start pulse in the middle of streaming
    v0 = int'(next_val);
    run_frame(1000, 0, 0, 30, 400);
    chk_eq("t5_contig", bad_contig(v0), 0);

    // 5: start+abort together in IDLE, ADC strobes in IDLE
    step(1, 1, 0, 1);
    chk_eq("t5_start_abort_busy", busy, 0);
    nb = beats.size();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1);
      chk_eq("t5_idle_valid", bus_if.out_valid, 0);
    end
    chk_eq("t5_idle_beats", beats.size(), nb);
    chk_eq("t5_idx_held", sample_idx, FL);

    // 6: async reset between edges mid-frame
    step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("t6_rst_valid", bus_if.out_valid, 0);
    chk_eq("t6_rst_data", bus_if.data_out, 0);
    chk_eq("t6_rst_last", bus_if.out_last, 0);
    chk_eq("t6_rst_busy", busy, 0);
    chk_eq("t6_rst_done", frame_done, 0);
    chk_eq("t6_rst_idx", sample_idx, 0);
    chk_eq("t6_rst_drops", drop_count, 0);
    chk_eq("t6_rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 6: long stall saturates drop_count (300 strobes, 5 stored)
    v0 = int'(next_val);
    run_frame(1, 300, 0, -1, 800);
    chk_eq("t6_drop_sat", drop_count, 255);
    chk_eq("t6_overflow", overflow, 1);
    if (beats.size() == FL) chk_eq("t6_first", beats[0], v0);
    chk_eq("t6_increasing", bad_increasing(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
